// File: rtl/mem_responder_if.sv
// MOV/MOC memory handshake between the control unit (master) and the memory responder (slave).
interface mem_responder_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  typeData;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV, RW, typeData, Address, DataIn,
    input  DataOut, MOC, ERR
  );

  modport slave (
    input  MOV, RW, typeData, Address, DataIn,
    output DataOut, MOC, ERR
  );
endinterface

// File: rtl/mem_responder.sv
// Big-endian byte-addressed memory with programmable wait states behind the MOV/MOC handshake.
// Accesses are latched in IDLE and performed once the wait-state counter expires.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            CLR,
  mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         dout_q, dout_d;
  logic                moc_q, moc_d;
  logic                err_q, err_d;

  logic [7:0]          mem [0:DEPTH-1];

  logic                mem_we;
  logic                reject;
  logic [ADDR_W-1:0]   a1, a2, a3;
  logic [31:0]         rdata;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^bus.Address[31:ADDR_W];

  // Offsets are ORed into the low bits: only aligned accesses ever use them, so no carry.
  assign a1 = {addr_q[ADDR_W-1:1], 1'b1};
  assign a2 = {addr_q[ADDR_W-1:2], 2'b10};
  assign a3 = {addr_q[ADDR_W-1:2], 2'b11};

  always_comb begin
    reject = 1'b1;
    rdata  = '0;
    case (size_q)
      2'b00: begin
        reject = 1'b0;
        rdata  = {24'h0, mem[addr_q]};
      end
      2'b01: begin
        reject = addr_q[0];
        rdata  = {16'h0, mem[addr_q], mem[a1]};
      end
      2'b10: begin
        reject = |addr_q[1:0];
        rdata  = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
      end
      default: begin
        reject = 1'b1;
        rdata  = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          addr_d  = bus.Address[ADDR_W-1:0];
          rw_d    = bus.RW;
          size_d  = bus.typeData;
          din_d   = bus.DataIn;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.MOV) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          state_d = ACK;
          if (reject) begin
            dout_d = '0;
            err_d  = 1'b1;
          end else begin
            err_d = 1'b0;
            if (rw_q) dout_d = rdata;
            else      mem_we = 1'b1;
          end
        end
      end
      ACK: begin
        if (!bus.MOV) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset so preloaded contents survive CLR.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      case (size_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1]     <= din_q[7:0];
        end
        2'b10: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1]     <= din_q[23:16];
          mem[a2]     <= din_q[15:8];
          mem[a3]     <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.ERR     = err_q;

endmodule
